// File: rtl/fp_unit_pkg.sv
// fp_unit shared definitions: FSM states and binary32 field constants.
// Imported by fp_unit and fp_unit_lzc.
package fp_unit_pkg;

   localparam int EXP_BIAS = 127;
   localparam int EXP_W    = 8;
   localparam int MAN_W    = 23;

   localparam logic [31:0] QNAN    = 32'h7FC00000;
   localparam logic [31:0] POS_INF = 32'h7F800000;

   typedef enum logic [1:0] {
      IDLE,
      UNPACK,
      EXEC,
      NORM
   } state_t;

endpackage

// File: rtl/fp_unit_lzc.sv
// fp_unit_lzc: combinational leading-zero counter.
// cnt = W when din is all zero.
module fp_unit_lzc
   import fp_unit_pkg::*;
#(
   parameter int W  = 28,
   parameter int CW = 5
) (
   input  logic [W-1:0]  din,
   output logic [CW-1:0] cnt,
   output logic          zero
);

   logic found;

   // scan from the msb for the first set bit
   always_comb begin
      cnt   = CW'(W);
      found = 1'b0;
      for (int i = W - 1; i >= 0; i--) begin
         if (!found && din[i]) begin
            cnt   = CW'(W - 1 - i);
            found = 1'b1;
         end
      end
   end

   assign zero = ~found;

endmodule

// File: rtl/fp_unit.sv
// fp_unit: multi-cycle binary32 add/multiply, flush-to-zero.
// Truncating by default; define FP_RNE_EN for round-to-nearest-even.
module fp_unit
#(
   parameter int width = 32
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             FP_Start,
   input  logic             FPUnitOp,
   input  logic [width-1:0] FP_Operand1,
   input  logic [width-1:0] FP_Operand2,
   output logic [width-1:0] Result,
   output logic             FP_Busy
);
   import fp_unit_pkg::*;

   state_t state, nstate;

   logic             op_q;
   logic [width-1:0] a_q, b_q;

   logic             u_spec;
   logic [31:0]      u_val;
   logic             u_s1, u_s2;
   logic [EXP_W-1:0] u_e1, u_e2;
   logic [MAN_W:0]   u_m1, u_m2;

   logic               x_sign;
   logic signed [9:0]  x_e;
   logic [27:0]        x_v;

   logic             sa, sb;
   logic [EXP_W-1:0] ea, eb;
   logic [MAN_W-1:0] fa, fb;
   logic             nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
   logic             spec;
   logic [31:0]      val;

   assign sa = a_q[31];
   assign sb = b_q[31];
   assign ea = a_q[MAN_W +: EXP_W];
   assign eb = b_q[MAN_W +: EXP_W];
   assign fa = a_q[MAN_W-1:0];
   assign fb = b_q[MAN_W-1:0];
   assign nan_a  = (&ea) & (|fa);
   assign nan_b  = (&eb) & (|fb);
   assign inf_a  = (&ea) & ~(|fa);
   assign inf_b  = (&eb) & ~(|fb);
   assign zero_a = ~(|ea);
   assign zero_b = ~(|eb);

   // state register
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) state <= IDLE;
      else        state <= nstate;
   end

   // next-state: one step per cycle once started
   always_comb begin
      nstate = state;
      case (state)
         IDLE:    if (FP_Start) nstate = UNPACK;
         UNPACK:  nstate = EXEC;
         EXEC:    nstate = NORM;
         NORM:    nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end

   // busy covers the start cycle plus the three working states
   always_comb begin
      FP_Busy = RESET & ((state == IDLE && FP_Start) || state != IDLE);
   end

   // special-operand decode; subnormals already count as zero
   always_comb begin
      spec = 1'b1;
      val  = QNAN;
      if (nan_a || nan_b) begin
         val = QNAN;
      end else if (!op_q) begin
         if (inf_a && inf_b && (sa ^ sb)) val = QNAN;
         else if (inf_a)                  val = {sa, POS_INF[30:0]};
         else if (inf_b)                  val = {sb, POS_INF[30:0]};
         else if (zero_a && zero_b)       val = {sa & sb, 31'b0};
         else if (zero_a)                 val = b_q;
         else if (zero_b)                 val = a_q;
         else                             spec = 1'b0;
      end else begin
         if ((inf_a && zero_b) || (zero_a && inf_b)) val = QNAN;
         else if (inf_a || inf_b)  val = {sa ^ sb, POS_INF[30:0]};
         else if (zero_a || zero_b) val = {sa ^ sb, 31'b0};
         else                       spec = 1'b0;
      end
   end

   logic             a_big, big_s;
   logic [EXP_W-1:0] big_e, sml_e, diff;
   logic [MAN_W:0]   big_m, sml_m;
   logic [26:0]      aext, bext, bsh, mask;
   logic [27:0]      add_v, mul_v, ex_v;
   logic [47:0]      prod;
   logic signed [9:0] ex_e;
   logic             ex_s;

   // significand datapath: aligned add/sub or 24x24 product
   always_comb begin
      a_big = {u_e1, u_m1} >= {u_e2, u_m2};
      big_s = a_big ? u_s1 : u_s2;
      big_e = a_big ? u_e1 : u_e2;
      sml_e = a_big ? u_e2 : u_e1;
      big_m = a_big ? u_m1 : u_m2;
      sml_m = a_big ? u_m2 : u_m1;
      diff  = big_e - sml_e;
      aext  = {big_m, 3'b0};
      bext  = {sml_m, 3'b0};
      mask  = '0;
      if (diff >= 8'd27) begin
         bsh = {26'b0, |bext};
      end else begin
         mask = (27'h1 << diff) - 27'h1;
         bsh  = (bext >> diff) | {26'b0, |(bext & mask)};
      end
      if (u_s1 ^ u_s2) add_v = {1'b0, aext} - {1'b0, bsh};
      else             add_v = {1'b0, aext} + {1'b0, bsh};
      prod  = u_m1 * u_m2;
      mul_v = {prod[47:21], |prod[20:0]};
      if (op_q) begin
         ex_v = mul_v;
         ex_e = {2'b0, u_e1} + {2'b0, u_e2} - 10'(EXP_BIAS);
         ex_s = u_s1 ^ u_s2;
      end else begin
         ex_v = add_v;
         ex_e = {2'b0, big_e};
         ex_s = big_s;
      end
   end

   logic [4:0]        lz, sh;
   logic              vz, inc, nv_unused;
   logic [27:0]       nv;
   logic signed [9:0] ne, ef;
   logic [24:0]       mr;
   logic [22:0]       frac;
   logic [31:0]       res;

   fp_unit_lzc #(.W(28), .CW(5)) u_lzc (
      .din  (x_v),
      .cnt  (lz),
      .zero (vz)
   );

   assign nv_unused = ^{nv[27], nv[2:0]};

   // normalise, round, then range-check and pack
   always_comb begin
      sh = 5'd0;
      nv = x_v;
      ne = x_e;
      if (x_v[27]) begin
         nv = {1'b0, x_v[27:2], |x_v[1:0]};
         ne = x_e + 10'sd1;
      end else if (!vz) begin
         sh = lz - 5'd1;
         nv = x_v << sh;
         ne = x_e - $signed({5'b0, sh});
      end
`ifdef FP_RNE_EN
      inc = nv[2] & (nv[1] | nv[0] | nv[3]);
`else
      inc = 1'b0;
`endif
      mr = {1'b0, nv[26:3]} + {24'b0, inc};
      if (mr[24]) begin
         frac = mr[23:1];
         ef   = ne + 10'sd1;
      end else begin
         frac = mr[22:0];
         ef   = ne;
      end
      if (u_spec)              res = u_val;
      else if (vz)             res = 32'h0;
      else if (ef >= 10'sd255) res = {x_sign, POS_INF[30:0]};
      else if (ef <= 10'sd0)   res = {op_q & x_sign, 31'b0};
      else                     res = {x_sign, ef[7:0], frac};
   end

   // pipeline of per-state registers; Result loads leaving NORM
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         op_q   <= 1'b0;
         a_q    <= '0;
         b_q    <= '0;
         u_spec <= 1'b0;
         u_val  <= '0;
         u_s1   <= 1'b0;
         u_s2   <= 1'b0;
         u_e1   <= '0;
         u_e2   <= '0;
         u_m1   <= '0;
         u_m2   <= '0;
         x_sign <= 1'b0;
         x_e    <= '0;
         x_v    <= '0;
         Result <= '0;
      end else begin
         if (state == IDLE && FP_Start) begin
            op_q <= FPUnitOp;
            a_q  <= FP_Operand1;
            b_q  <= FP_Operand2;
         end
         if (state == UNPACK) begin
            u_spec <= spec;
            u_val  <= val;
            u_s1   <= sa;
            u_s2   <= sb;
            u_e1   <= ea;
            u_e2   <= eb;
            u_m1   <= {1'b1, fa};
            u_m2   <= {1'b1, fb};
         end
         if (state == EXEC) begin
            x_sign <= ex_s;
            x_e    <= ex_e;
            x_v    <= ex_v;
         end
         if (state == NORM) Result <= res;
      end
   end

endmodule

// File: tb/tb_fp_unit.sv
// tb_fp_unit: directed binary32 add/mul vectors, handshake
// timing and asynchronous reset behaviour of fp_unit.
module tb_fp_unit;

   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic        FP_Start = 1'b1;
   logic        FPUnitOp = 1'b0;
   logic [31:0] FP_Operand1 = '0;
   logic [31:0] FP_Operand2 = '0;
   logic [31:0] Result;
   logic        FP_Busy;

   int checks = 0;
   int errors = 0;

   fp_unit #(.width(32)) dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .FP_Start    (FP_Start),
      .FPUnitOp    (FPUnitOp),
      .FP_Operand1 (FP_Operand1),
      .FP_Operand2 (FP_Operand2),
      .Result      (Result),
      .FP_Busy     (FP_Busy)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   // start one op, hold FP_Start a second cycle with altered
   // inputs, count busy cycles, then check Result
   task automatic do_op(input logic op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_r,
                        input string tag, input bit rel);
      int n;
      @(negedge CLK);
      if (rel) RESET = 1'b1;
      FPUnitOp    = op;
      FP_Operand1 = a;
      FP_Operand2 = b;
      FP_Start    = 1'b1;
      #1;
      n = FP_Busy ? 1 : 0;
      @(negedge CLK);
      FPUnitOp    = ~op;
      FP_Operand1 = ~a;
      FP_Operand2 = b ^ 32'h0040_0001;
      #1;
      for (int i = 0; i < 8 && FP_Busy; i++) begin
         n++;
         @(negedge CLK);
         FP_Start = 1'b0;
         #1;
      end
      chk({tag, " busy"}, 32'(n), 32'd4);
      chk(tag, Result, exp_r);
   endtask

   logic [31:0] tiny_exp;

   initial begin
`ifdef FP_RNE_EN
      tiny_exp = 32'h3F800001;
`else
      tiny_exp = 32'h3F800000;
`endif
      #12;
      chk("rst busy", 32'(FP_Busy), 32'd0);
      chk("rst result", Result, 32'h0);
      FP_Start = 1'b0;

      do_op(1'b0, 32'h42400000, 32'h40A00000, 32'h42540000, "add48_5", 1'b1);

      @(negedge CLK);
      FPUnitOp    = 1'b1;
      FP_Operand1 = 32'h42C80000;
      FP_Operand2 = 32'h43480000;
      FP_Start    = 1'b1;
      @(negedge CLK);
      FP_Start = 1'b0;
      @(negedge CLK);
      RESET = 1'b0;
      #1;
      chk("midrst busy", 32'(FP_Busy), 32'd0);
      chk("midrst result", Result, 32'h0);

      do_op(1'b1, 32'h42400000, 32'h40A00000, 32'h43700000, "mul48_5", 1'b1);
      do_op(1'b0, 32'hC2400000, 32'hC0A00000, 32'hC2540000, "addneg", 1'b0);
      do_op(1'b1, 32'hC2400000, 32'hC0A00000, 32'h43700000, "mulneg", 1'b0);
      do_op(1'b0, 32'h42C80000, 32'h43480000, 32'h43960000, "add100_200", 1'b0);
      do_op(1'b1, 32'h42C80000, 32'h43480000, 32'h469C4000, "mul100_200", 1'b0);
      do_op(1'b0, 32'hBF000000, 32'h3F99999A, 32'h3F333334, "addfrac", 1'b0);
      do_op(1'b1, 32'hBF000000, 32'h3F99999A, 32'hBF19999A, "mulfrac", 1'b0);

      repeat (2) @(negedge CLK);
      chk("hold", Result, 32'hBF19999A);

      do_op(1'b0, 32'h00000000, 32'h4248CCCC, 32'h4248CCCC, "addzero", 1'b0);
      do_op(1'b1, 32'h00000000, 32'h4248CCCC, 32'h00000000, "mulzero", 1'b0);
      do_op(1'b0, 32'h00800010, 32'h80800001, 32'h00000000, "addunder", 1'b0);
      do_op(1'b1, 32'h00800010, 32'h80800001, 32'h80000000, "mulunder", 1'b0);
      do_op(1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, "addovf", 1'b0);
      do_op(1'b1, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, "mulovf", 1'b0);
      do_op(1'b0, 32'h7F800000, 32'h1FFFFFF0, 32'h7F800000, "addinf", 1'b0);
      do_op(1'b1, 32'h7F800000, 32'h1FFFFFF0, 32'h7F800000, "mulinf", 1'b0);
      do_op(1'b0, 32'h7F800000, 32'h00000003, 32'h7F800000, "addinfsub", 1'b0);
      do_op(1'b1, 32'h7F800000, 32'h00000003, 32'h7FC00000, "mulinfsub", 1'b0);
      do_op(1'b0, 32'h7F800003, 32'h7F800004, 32'h7FC00000, "addnan", 1'b0);
      do_op(1'b1, 32'h7F800003, 32'h7F800004, 32'h7FC00000, "mulnan", 1'b0);
      do_op(1'b0, 32'h00000003, 32'h7F800004, 32'h7FC00000, "addsubnan", 1'b0);
      do_op(1'b1, 32'h00000003, 32'h7F800004, 32'h7FC00000, "mulsubnan", 1'b0);
      do_op(1'b0, 32'h7F800000, 32'hFF800000, 32'h7FC00000, "infminf", 1'b0);
      do_op(1'b0, 32'h80000000, 32'h80000000, 32'h80000000, "negzeros", 1'b0);
      do_op(1'b0, 32'h3F800000, 32'hBF800000, 32'h00000000, "cancel", 1'b0);
      do_op(1'b0, 32'h3F800000, 32'h33800001, tiny_exp, "rounding", 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fp_unit.md
FP_UNIT -- requirements
Module: fp_unit

Interface
REQ-001 SHALL have parameter: width, 32, operand/result width; only 32 (IEEE-754 binary32) is supported.
REQ-002 SHALL have port: CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: RESET  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: FP_Start  input  1  one-cycle request pulse.
REQ-005 SHALL have port: FPUnitOp  input  1  0 = add (Op1+Op2), 1 = multiply (Op1*Op2).
REQ-006 SHALL have port: FP_Operand1  input  width  first binary32 operand.
REQ-007 SHALL have port: FP_Operand2  input  width  second binary32 operand.
REQ-008 SHALL have port: Result  output  width  registered binary32 result.
REQ-009 SHALL have port: FP_Busy  output  1  operation in progress.

Function
REQ-010 SHALL use FSM states IDLE -> UNPACK -> EXEC -> NORM -> IDLE, advancing one state per cycle after leaving IDLE.
REQ-011 SHALL leave IDLE only when FP_Start=1 and the state is IDLE; on that edge it captures FP_Operand1, FP_Operand2 and FPUnitOp, so later input changes have no effect.
REQ-012 SHALL drive FP_Busy combinationally high when (IDLE and FP_Start=1) or state != IDLE; otherwise low, giving a 4-cycle busy window.
REQ-013 SHALL load Result on the NORM->IDLE edge and hold it until the next completion; FP_Start while busy is ignored.
REQ-014 SHALL flush subnormal inputs to signed zero, and flush subnormal or underflowed results to +0 for add and to sign-XOR zero for multiply.
REQ-015 SHALL return canonical quiet NaN 32'h7FC00000 for any NaN input, Inf-Inf of opposite signs (add), and Inf*0 (multiply, after flush).
REQ-016 SHALL return Inf with the correct sign for an Inf operand otherwise, and for exponent overflow (biased exponent >= 255) regardless of rounding mode.
REQ-017 Add SHALL align the smaller-exponent significand using 3 extra bits (guard, round, sticky), add or subtract magnitudes, and renormalise with a leading-zero count.
REQ-018 Add SHALL give an exact-zero result of +0, except (-0)+(-0) = -0.
REQ-019 Multiply SHALL form a 24x24 -> 48-bit significand product, give sign = s1 XOR s2 and exponent = e1+e2-127, and normalise by at most one position.
REQ-020 SHALL round by truncation (toward zero) unless FP_RNE_EN is defined.
REQ-021 SHALL renormalise when rounding carries out of the significand, incrementing the exponent, with a re-check for overflow.

Reset
REQ-022 SHALL, while RESET=0, immediately force state=IDLE, Result=32'h00000000, FP_Busy=0 and all internal registers to 0, including during an operation in progress.
REQ-023 SHALL accept FP_Start on the first rising edge after RESET deasserts.

Configuration
REQ-024 SHALL, with macro FP_RNE_EN defined, round to nearest, ties to even, using guard/round/sticky bits; without it, SHALL truncate; no other behaviour SHALL differ.

Structure
REQ-025 SHALL place in shared package fp_unit_pkg: the state enum typedef, EXP_BIAS=127, EXP_W=8, MAN_W=23, QNAN=32'h7FC00000, and POS_INF=32'h7F800000.
REQ-026 SHALL use one sub-module, fp_unit_lzc, a combinational leading-zero counter used by add normalisation.

Verification
REQ-027 SHALL cover 48.0+5.0 and 48.0*5.0: 42400000 op 40A00000 -> add 42540000, mul 43700000; negated operands C2400000/C0A00000 -> add C2540000, mul 43700000.
REQ-028 SHALL cover 42C80000 op 43480000 -> add 43960000, mul 469C4000; BF000000 op 3F99999A -> add 3F333334, mul BF19999A, in both rounding configurations.
REQ-029 SHALL cover 00000000 op 4248CCCC -> add 4248CCCC, mul 00000000; 00800010 op 80800001 -> add 00000000 (flushed), mul 80000000.
REQ-030 SHALL cover 7F7FFFFF op 7F7FFFFF -> add 7F800000, mul 7F800000; 7F800000 op 1FFFFFF0 -> 7F800000 for both operations.
REQ-031 SHALL cover 7F800000 op 00000003 -> add 7F800000, mul 7FC00000; 7F800003 op 7F800004 -> 7FC00000 for both; 00000003 op 7F800004 -> 7FC00000 for both.
REQ-032 SHALL check the handshake: FP_Busy high exactly 4 cycles from the FP_Start cycle, and Result valid when FP_Busy falls; RESET pulled low mid-operation -> FP_Busy=0 and Result=0 immediately.
